instr_stream_writer: RTL and testbench
======================================

# instr_stream_writer

Sequential instruction encoder and loader for the single-cycle MIPS core. It accepts symbolic instruction commands over a valid/ready handshake and assembles each into a 32-bit MIPS word. The field layout is the exact inverse of the main control decoder's opcode map. It writes the words into instruction memory at consecutive word addresses, and the bench and boot logic use it to preload programs before the core leaves reset.

## Interface

Parameters:
- ADDR_W, 8, instruction-memory word-address width
- BASE_ADDR, 0, first word address written after reset or after a completed program

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_kind  in  3  0=RTYPE, 1=ADDI, 2=BNE, 3=SLTI, 4=XORI, 5=JAL, 6/7 illegal
- cmd_rs, cmd_rt, cmd_rd, cmd_shamt  in  5 each  register/shift fields
- cmd_funct  in  6  R-type function field
- cmd_imm  in  26  bits [15:0] for I-types, bits [25:0] for JAL
- cmd_last  in  1  this command ends the program
- mem_wr_valid  out  1  write request to instruction memory
- mem_wr_ready  in  1  memory accepts the write
- mem_addr  out  ADDR_W  word address of the current write
- mem_wdata  out  32  encoded instruction
- done  out  1  one-cycle pulse when a program is complete
- wr_count  out  ADDR_W+1  words written since reset or the last done
- err_illegal  out  1  sticky flag, illegal cmd_kind seen
- err_wrap  out  1  sticky flag, address wrapped past 2^ADDR_W-1

## Operation

Encoding rules. Immediates are passed raw, because sign or zero extension is the datapath's job.
- RTYPE: {6'b000000, rs, rt, rd, shamt, funct}
- ADDI: {6'b001000, rs, rt, imm[15:0]}
- BNE: {6'b000101, rs, rt, imm[15:0]}
- SLTI: {6'b001010, rs, rt, imm[15:0]}
- XORI: {6'b001110, rs, rt, imm[15:0]}
- JAL: {6'b000011, imm[25:0]}

State machine, states IDLE and WRITE:
- IDLE, cmd_valid&cmd_ready, legal kind: register the encoded word and cmd_last, then go to WRITE.
- IDLE, cmd_valid&cmd_ready, illegal kind: nothing is written and the address is unchanged. Set err_illegal and stay in IDLE. If cmd_last is set, pulse done next cycle and apply the end-of-program actions below.
- WRITE: hold mem_wr_valid, mem_addr and mem_wdata stable until mem_wr_ready. On the handshake:
  - increment mem_addr modulo 2^ADDR_W and increment wr_count
  - return to IDLE
- Handshake completes at address 2^ADDR_W-1 and the registered last is clear: mem_addr wraps to 0 and err_wrap is set.
- Handshake completes with registered last set: pulse done next cycle, reload mem_addr to BASE_ADDR, clear wr_count to 0. err_wrap is not set in this case.
- err_illegal and err_wrap are cleared only by reset.

## Timing

- Reset values:
  - state IDLE, cmd_ready 1 (from the first cycle after reset)
  - mem_wr_valid 0, mem_wdata 0, mem_addr BASE_ADDR
  - done 0, wr_count 0, err_illegal 0, err_wrap 0
- Accept at edge N means mem_wr_valid=1 from cycle N+1. With mem_wr_ready tied high, the write completes at edge N+1 and cmd_ready returns at N+2.
- Peak throughput is one instruction per 2 cycles.
- cmd_ready is a pure state decode and does not depend on cmd_valid.
- done is high exactly in the cycle after the final handshake, or after an illegal last command is accepted.
- Reset asserted in WRITE: the in-flight word is dropped, with no partial write. mem_wr_valid is low from the cycle after the reset edge.
- No mem_wr_ready: the block stalls indefinitely with outputs stable.

## Structure

- The shared package holds:
  - opcode constants OP_RTYPE, OP_ADDI, OP_BNE, OP_SLTI, OP_XORI, OP_JAL, which the control decoder also uses
  - the cmd_kind enumeration
- One combinational sub-module, mips_instr_encode (kind, fields → word, illegal flag). It is reused by the bench's golden model.
- The top level holds the FSM, the address/count registers and the error flags.

## Test plan

- ADDI rs=0 rt=8 imm=5 with mem_wr_ready=1 → 0x20080005 at addr 0, mem_wr_valid for exactly 1 cycle, wr_count=1.
- Program of RTYPE (rs=1, rt=2, rd=3, funct=0x20) then BNE (rs=1, rt=2, imm=0xFFFE, last=1) → 0x00221820 @0, 0x1422FFFE @1. done pulses the next cycle, mem_addr returns to 0, wr_count becomes 0.
- SLTI (rs=4, rt=5, imm=10) with mem_wr_ready low for 3 cycles → word 0x2885000A and addr held stable for 4 cycles, cmd_ready low throughout.
- JAL imm=0x0100040, then XORI (rs=6, rt=6, imm=0xFFFF) → 0x0C100040 and 0x38C6FFFF at consecutive addresses.
- cmd_kind=7 with last=1 → no write, err_illegal=1, done pulses, address unchanged. A later legal command still writes.
- ADDR_W=2: five non-last commands → the fifth word lands at addr 0 and err_wrap=1. Reset asserted during WRITE → mem_wr_valid=0 and all outputs return to their reset values.

Source files
------------

// File: rtl/instr_stream_writer_pkg.sv
// Shared MIPS opcode map and command kinds.
// Used by the stream writer, its encoder and the control decoder.
package instr_stream_writer_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  typedef enum logic [2:0] {
    K_RTYPE = 3'd0,
    K_ADDI  = 3'd1,
    K_BNE   = 3'd2,
    K_SLTI  = 3'd3,
    K_XORI  = 3'd4,
    K_JAL   = 3'd5
  } cmd_kind_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } wr_state_e;

endpackage

// File: rtl/mips_instr_encode.sv
// Combinational MIPS word encoder: kind + fields -> 32-bit word.
// Ports: kind, rs, rt, rd, shamt, funct, imm in; word, illegal out.
module mips_instr_encode
  import instr_stream_writer_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  // Immediates go out raw; extension is done in the datapath.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (kind)
      K_RTYPE: word = {OP_RTYPE, rs, rt, rd, shamt, funct};
      K_ADDI:  word = {OP_ADDI, rs, rt, imm[15:0]};
      K_BNE:   word = {OP_BNE, rs, rt, imm[15:0]};
      K_SLTI:  word = {OP_SLTI, rs, rt, imm[15:0]};
      K_XORI:  word = {OP_XORI, rs, rt, imm[15:0]};
      K_JAL:   word = {OP_JAL, imm};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_stream_writer.sv
// Encodes symbolic commands and writes them to instruction memory
// at consecutive word addresses. Ports: cmd_* handshake in,
// mem_wr_* handshake out, done/wr_count/err_* status out.
module instr_stream_writer
  import instr_stream_writer_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_kind,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_shamt,
  input  logic [5:0]        cmd_funct,
  input  logic [25:0]       cmd_imm,
  input  logic              cmd_last,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  output logic              err_illegal,
  output logic              err_wrap
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  wr_state_e         state_q, state_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              eill_q, eill_d;
  logic              ewrap_q, ewrap_d;

  logic [31:0] enc_word;
  logic        enc_ill;

  mips_instr_encode u_enc (
    .kind    (cmd_kind),
    .rs      (cmd_rs),
    .rt      (cmd_rt),
    .rd      (cmd_rd),
    .shamt   (cmd_shamt),
    .funct   (cmd_funct),
    .imm     (cmd_imm),
    .word    (enc_word),
    .illegal (enc_ill)
  );

  always_comb begin
    state_d = state_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    eill_d  = eill_q;
    ewrap_d = ewrap_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (!enc_ill) begin
            wdata_d = enc_word;
            last_d  = cmd_last;
            state_d = S_WRITE;
          end else begin
            eill_d = 1'b1;
            // An illegal last command still closes the program.
            if (cmd_last) begin
              done_d = 1'b1;
              addr_d = BASE;
              cnt_d  = '0;
            end
          end
        end
      end
      S_WRITE: begin
        if (mem_wr_ready) begin
          state_d = S_IDLE;
          if (last_q) begin
            done_d = 1'b1;
            addr_d = BASE;
            cnt_d  = '0;
          end else begin
            addr_d = addr_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (addr_q == '1) ewrap_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wdata_q <= '0;
      last_q  <= 1'b0;
      addr_q  <= BASE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      eill_q  <= 1'b0;
      ewrap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      eill_q  <= eill_d;
      ewrap_q <= ewrap_d;
    end
  end

  assign cmd_ready    = (state_q == S_IDLE);
  assign mem_wr_valid = (state_q == S_WRITE);
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign done         = done_q;
  assign wr_count     = cnt_q;
  assign err_illegal  = eill_q;
  assign err_wrap     = ewrap_q;

endmodule

// File: tb/tb_instr_stream_writer.sv
// Directed bench for instr_stream_writer.
// Two instances: ADDR_W=8 for encoding/flow, ADDR_W=2 for wrap.
module tb_instr_stream_writer;

  logic        clk = 1'b0;
  logic        reset, reset2;
  logic        cmd_valid, cmd_valid2;
  logic        cmd_ready, cmd_ready2;
  logic [2:0]  cmd_kind;
  logic [4:0]  cmd_rs, cmd_rt, cmd_rd, cmd_shamt;
  logic [5:0]  cmd_funct;
  logic [25:0] cmd_imm;
  logic        cmd_last;
  logic        mem_wr_ready;
  logic        wv, wv2;
  logic [7:0]  addr;
  logic [1:0]  addr2;
  logic [31:0] wd, wd2;
  logic        done, done2;
  logic [8:0]  cnt;
  logic [2:0]  cnt2;
  logic        eill, eill2, ewrap, ewrap2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_stream_writer #(.ADDR_W(8), .BASE_ADDR(0)) u_dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
    .cmd_rd(cmd_rd), .cmd_shamt(cmd_shamt), .cmd_funct(cmd_funct),
    .cmd_imm(cmd_imm), .cmd_last(cmd_last),
    .mem_wr_valid(wv), .mem_wr_ready(mem_wr_ready),
    .mem_addr(addr), .mem_wdata(wd), .done(done),
    .wr_count(cnt), .err_illegal(eill), .err_wrap(ewrap)
  );

  instr_stream_writer #(.ADDR_W(2), .BASE_ADDR(0)) u_dut2 (
    .clk(clk), .reset(reset2),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_kind(cmd_kind), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
    .cmd_rd(cmd_rd), .cmd_shamt(cmd_shamt), .cmd_funct(cmd_funct),
    .cmd_imm(cmd_imm), .cmd_last(cmd_last),
    .mem_wr_valid(wv2), .mem_wr_ready(mem_wr_ready),
    .mem_addr(addr2), .mem_wdata(wd2), .done(done2),
    .wr_count(cnt2), .err_illegal(eill2), .err_wrap(ewrap2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for ready, holds valid for one edge; returns at accept+1.
  task automatic issue(input int sel,
                       input logic [2:0] k,
                       input logic [4:0] rs,
                       input logic [4:0] rt,
                       input logic [4:0] rd,
                       input logic [4:0] sh,
                       input logic [5:0] fn,
                       input logic [25:0] imm,
                       input logic last);
    int n = 0;
    while (!(sel == 0 ? cmd_ready : cmd_ready2) && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk("rdy_timeout", 32'd0, 32'd1);
    cmd_kind  = k;
    cmd_rs    = rs;
    cmd_rt    = rt;
    cmd_rd    = rd;
    cmd_shamt = sh;
    cmd_funct = fn;
    cmd_imm   = imm;
    cmd_last  = last;
    if (sel == 0) cmd_valid = 1'b1;
    else cmd_valid2 = 1'b1;
    step();
    cmd_valid  = 1'b0;
    cmd_valid2 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; reset2 = 1'b1;
    cmd_valid = 1'b0; cmd_valid2 = 1'b0;
    cmd_kind = '0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0;
    cmd_shamt = '0; cmd_funct = '0; cmd_imm = '0; cmd_last = 1'b0;
    mem_wr_ready = 1'b1;
    step();
    step();
    reset = 1'b0; reset2 = 1'b0;

    // reset state
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_wv", {31'd0, wv}, 32'd0);
    chk("rst_addr", {24'd0, addr}, 32'd0);
    chk("rst_wdata", wd, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cnt", {23'd0, cnt}, 32'd0);
    chk("rst_eill", {31'd0, eill}, 32'd0);
    chk("rst_ewrap", {31'd0, ewrap}, 32'd0);

    // ADDI single write
    issue(0, 3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 26'd5, 1'b0);
    chk("addi_wv", {31'd0, wv}, 32'd1);
    chk("addi_ready", {31'd0, cmd_ready}, 32'd0);
    chk("addi_word", wd, 32'h20080005);
    chk("addi_addr", {24'd0, addr}, 32'd0);
    step();
    chk("addi_wv_off", {31'd0, wv}, 32'd0);
    chk("addi_ready_back", {31'd0, cmd_ready}, 32'd1);
    chk("addi_cnt", {23'd0, cnt}, 32'd1);
    chk("addi_addr_inc", {24'd0, addr}, 32'd1);

    // RTYPE then BNE last
    do_reset();
    issue(0, 3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 26'd0, 1'b0);
    chk("rtype_word", wd, 32'h00221820);
    chk("rtype_addr", {24'd0, addr}, 32'd0);
    step();
    issue(0, 3'd2, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 26'hFFFE, 1'b1);
    chk("bne_word", wd, 32'h1422FFFE);
    chk("bne_addr", {24'd0, addr}, 32'd1);
    chk("bne_done_early", {31'd0, done}, 32'd0);
    step();
    chk("prog_done", {31'd0, done}, 32'd1);
    chk("prog_addr", {24'd0, addr}, 32'd0);
    chk("prog_cnt", {23'd0, cnt}, 32'd0);
    chk("prog_ewrap", {31'd0, ewrap}, 32'd0);
    step();
    chk("prog_done_off", {31'd0, done}, 32'd0);

    // SLTI with memory stall
    mem_wr_ready = 1'b0;
    issue(0, 3'd3, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 26'd10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("stall_wv", {31'd0, wv}, 32'd1);
      chk("stall_word", wd, 32'h2885000A);
      chk("stall_addr", {24'd0, addr}, 32'd0);
      chk("stall_ready", {31'd0, cmd_ready}, 32'd0);
      if (i == 3) mem_wr_ready = 1'b1;
      step();
    end
    chk("stall_wv_off", {31'd0, wv}, 32'd0);
    chk("stall_addr_inc", {24'd0, addr}, 32'd1);

    // JAL then XORI
    issue(0, 3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 26'h0100040, 1'b0);
    chk("jal_word", wd, 32'h0C100040);
    chk("jal_addr", {24'd0, addr}, 32'd1);
    step();
    issue(0, 3'd4, 5'd6, 5'd6, 5'd0, 5'd0, 6'd0, 26'hFFFF, 1'b0);
    chk("xori_word", wd, 32'h38C6FFFF);
    chk("xori_addr", {24'd0, addr}, 32'd2);
    step();
    chk("xori_cnt", {23'd0, cnt}, 32'd3);

    // illegal, not last: no write, address kept
    issue(0, 3'd6, 5'd1, 5'd1, 5'd1, 5'd0, 6'd0, 26'd0, 1'b0);
    chk("ill6_wv", {31'd0, wv}, 32'd0);
    chk("ill6_eill", {31'd0, eill}, 32'd1);
    chk("ill6_done", {31'd0, done}, 32'd0);
    chk("ill6_addr", {24'd0, addr}, 32'd3);

    // illegal last after reset, then a legal write
    do_reset();
    chk("rst2_eill", {31'd0, eill}, 32'd0);
    issue(0, 3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 26'd0, 1'b1);
    chk("ill7_wv", {31'd0, wv}, 32'd0);
    chk("ill7_eill", {31'd0, eill}, 32'd1);
    chk("ill7_done", {31'd0, done}, 32'd1);
    chk("ill7_addr", {24'd0, addr}, 32'd0);
    step();
    chk("ill7_done_off", {31'd0, done}, 32'd0);
    issue(0, 3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 26'd5, 1'b0);
    chk("post_ill_wv", {31'd0, wv}, 32'd1);
    chk("post_ill_word", wd, 32'h20080005);
    chk("post_ill_addr", {24'd0, addr}, 32'd0);
    step();
    chk("post_ill_cnt", {23'd0, cnt}, 32'd1);

    // ADDR_W=2 wrap
    for (int i = 1; i <= 5; i++) begin
      issue(1, 3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 26'(i), 1'b0);
      chk("wrap_word", wd2, 32'h20080000 | 32'(i));
      chk("wrap_addr", {30'd0, addr2}, 32'((i - 1) % 4));
      step();
      if (i == 3) chk("wrap_ewrap_pre", {31'd0, ewrap2}, 32'd0);
      if (i == 4) chk("wrap_ewrap", {31'd0, ewrap2}, 32'd1);
    end
    chk("wrap_cnt", {29'd0, cnt2}, 32'd5);
    chk("wrap_addr_end", {30'd0, addr2}, 32'd1);

    // reset during WRITE drops the word
    mem_wr_ready = 1'b0;
    issue(1, 3'd4, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 26'h1234, 1'b0);
    chk("inflight_wv", {31'd0, wv2}, 32'd1);
    reset2 = 1'b1;
    step();
    chk("rstw_wv", {31'd0, wv2}, 32'd0);
    chk("rstw_addr", {30'd0, addr2}, 32'd0);
    chk("rstw_wdata", wd2, 32'd0);
    chk("rstw_cnt", {29'd0, cnt2}, 32'd0);
    chk("rstw_ewrap", {31'd0, ewrap2}, 32'd0);
    chk("rstw_eill", {31'd0, eill2}, 32'd0);
    chk("rstw_done", {31'd0, done2}, 32'd0);
    chk("rstw_ready", {31'd0, cmd_ready2}, 32'd1);
    reset2 = 1'b0;
    mem_wr_ready = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
